uart_rx_frame_checker: RTL



---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_parity_checker.sv | 21 ++
 rtl/uart_rx_frame_checker.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding and parity-type constants.
// The parity constants are common to the TX and RX paths.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_parity_checker.sv
// Combinational parity check of a received word against its parity bit.
// Zero latency, no flow control; mirrors the TX parity calculator.
module uart_rx_parity_checker
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    input  logic                  rx_bit,
    output logic                  mismatch
);

    logic expected;

    always_comb begin
        expected = (^data) ^ (par_typ == PAR_ODD);
        mismatch = (rx_bit != expected);
    end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART RX deserializer with parity/stop checking, advancing one step per mid-bit strobe.
// Word and DATA_VALID appear the edge after the stop strobe; no backpressure, strobe-paced.
module uart_rx_frame_checker
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SAMPLE_VALID,
    input  logic                  SAMPLE_BIT,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    rx_state_t             state_q;
    rx_state_t             state_d;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_typ_q;

    logic                  start_acc;
    logic                  shift_en;
    logic                  par_chk;
    logic                  stop_chk;
    logic                  last_bit;
    logic                  par_mismatch;

    assign last_bit = (cnt_q == CW'(DATA_WIDTH - 1));

    uart_rx_parity_checker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par_chk (
        .data     (shift_q),
        .par_typ  (par_typ_q),
        .rx_bit   (SAMPLE_BIT),
        .mismatch (par_mismatch)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (SAMPLE_VALID) begin
            case (state_q)
                IDLE:    if (!SAMPLE_BIT) state_d = DATA;
                DATA:    if (last_bit)    state_d = par_en_q ? PARITY : STOP;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        start_acc = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        if (SAMPLE_VALID) begin
            case (state_q)
                IDLE:    start_acc = !SAMPLE_BIT;
                DATA:    shift_en  = 1'b1;
                PARITY:  par_chk   = 1'b1;
                STOP:    stop_chk  = 1'b1;
                default: start_acc = 1'b0;
            endcase
        end
    end

    // DATA_VALID defaults low every cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (start_acc) begin
                cnt_q     <= '0;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                PAR_ERR   <= 1'b0;
                STP_ERR   <= 1'b0;
                BUSY      <= 1'b1;
            end
            if (shift_en) begin
                shift_q <= {SAMPLE_BIT, shift_q[DATA_WIDTH-1:1]};
                cnt_q   <= cnt_q + 1'b1;
            end
            if (par_chk) begin
                PAR_ERR <= par_mismatch;
            end
            if (stop_chk) begin
                BUSY    <= 1'b0;
                STP_ERR <= ~SAMPLE_BIT;
                if (SAMPLE_BIT && !PAR_ERR) begin
                    P_DATA     <= shift_q;
                    DATA_VALID <= 1'b1;
                end
            end
        end
    end

endmodule
